// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared AHB, access-size and data-bus FSM definitions
package msrv32_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR, ST_RESP} state_t;
endpackage

// File: rtl/msrv32_dbus_ctrl_if.sv
// msrv32_dbus_ctrl_if: core request/response and AHB-Lite data-port signals
interface msrv32_dbus_ctrl_if;
  logic req_valid_in, req_ready_out, req_write_in;
  logic [31:0] req_addr_in, req_wdata_in;
  logic [1:0] req_size_in;
  logic [3:0] req_mask_in;
  logic rsp_valid_out, rsp_err_out, stall_out;
  logic [31:0] rsp_rdata_out;
  logic [31:0] ahb_haddr_out, ahb_hwdata_out, ahb_hrdata_in;
  logic [1:0] ahb_htrans_out;
  logic ahb_hwrite_out, ahb_hready_in, ahb_hresp_in;
  logic [2:0] ahb_hsize_out;
  logic [3:0] ahb_hwstrb_out;
  modport master (
    input req_valid_in, req_write_in, req_addr_in, req_size_in, req_wdata_in, req_mask_in,
    input ahb_hready_in, ahb_hresp_in, ahb_hrdata_in,
    output req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out, stall_out,
    output ahb_haddr_out, ahb_htrans_out, ahb_hwrite_out, ahb_hsize_out, ahb_hwdata_out, ahb_hwstrb_out
  );
  modport slave (
    output req_valid_in, req_write_in, req_addr_in, req_size_in, req_wdata_in, req_mask_in,
    output ahb_hready_in, ahb_hresp_in, ahb_hrdata_in,
    input req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out, stall_out,
    input ahb_haddr_out, ahb_htrans_out, ahb_hwrite_out, ahb_hsize_out, ahb_hwdata_out, ahb_hwstrb_out
  );
endinterface

// File: rtl/msrv32_misalign_chk.sv
// msrv32_misalign_chk: flags accesses not naturally aligned to their size
module msrv32_misalign_chk
  import msrv32_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] size,
  output logic       err
);
  assign err = (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00) || size == 2'b11;
endmodule

// File: rtl/msrv32_dbus_ctrl.sv
// msrv32_dbus_ctrl: sequences single loads/stores onto the AHB-Lite data port
module msrv32_dbus_ctrl
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk_in,
  input logic rst_in,
  msrv32_dbus_ctrl_if.master bus
);
  localparam int CW = TIMEOUT_CYCLES < 2 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  logic err_n, mis, wr_q, ready_q, stall_q, rsp_valid_q, rsp_err_q;
  logic [31:0] addr_q, wdata_q, rdata_q, hwdata_q;
  logic [1:0] size_q, htrans_q;
  logic [3:0] mask_q, hwstrb_q;
  logic [CW-1:0] cnt;
  msrv32_misalign_chk u_chk (.addr(bus.req_addr_in[1:0]), .size(bus.req_size_in), .err(mis));
  always_comb begin
    state_n = state;
    err_n = 1'b0;
    case (state)
      ST_IDLE: if (bus.req_valid_in) begin
        state_n = mis ? ST_RESP : ST_ADDR;
        err_n = mis;
      end
      ST_ADDR: state_n = bus.ahb_hready_in ? ST_DATA : ST_ADDR;
      ST_DATA: if (bus.ahb_hready_in) begin
        state_n = ST_RESP;
        err_n = bus.ahb_hresp_in;
      end else if (bus.ahb_hresp_in) begin
        state_n = ST_ERR;
      end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
        state_n = ST_RESP;
        err_n = 1'b1;
      end
      ST_ERR: if (bus.ahb_hready_in) begin
        state_n = ST_RESP;
        err_n = 1'b1;
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
      wr_q <= 1'b0;
      addr_q <= '0;
      size_q <= '0;
      wdata_q <= '0;
      mask_q <= '0;
      cnt <= '0;
      htrans_q <= HTRANS_IDLE;
      hwdata_q <= '0;
      hwstrb_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rdata_q <= '0;
      stall_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && bus.req_valid_in) begin
        wr_q <= bus.req_write_in;
        addr_q <= bus.req_addr_in;
        size_q <= bus.req_size_in;
        wdata_q <= bus.req_wdata_in;
        mask_q <= bus.req_mask_in;
      end
      cnt <= state != ST_DATA ? '0 : cnt + CW'(cnt != CW'(TIMEOUT_CYCLES) && !bus.ahb_hready_in && !bus.ahb_hresp_in);
      htrans_q <= state_n == ST_ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
      hwdata_q <= state_n == ST_DATA && wr_q ? wdata_q : '0;
      hwstrb_q <= state_n == ST_DATA && wr_q ? mask_q : '0;
      rsp_valid_q <= state_n == ST_RESP;
      rsp_err_q <= state_n == ST_RESP && err_n;
      rdata_q <= state == ST_DATA && state_n == ST_RESP && !err_n && !wr_q ? bus.ahb_hrdata_in : '0;
      stall_q <= state_n inside {ST_ADDR, ST_DATA, ST_ERR};
      ready_q <= state_n == ST_IDLE;
    end
  end
  assign bus.req_ready_out = ready_q;
  assign bus.stall_out = stall_q;
  assign bus.rsp_valid_out = rsp_valid_q;
  assign bus.rsp_err_out = rsp_err_q;
  assign bus.rsp_rdata_out = rdata_q;
  assign bus.ahb_haddr_out = addr_q;
  assign bus.ahb_hwrite_out = wr_q;
  assign bus.ahb_hsize_out = {1'b0, size_q};
  assign bus.ahb_htrans_out = htrans_q;
  assign bus.ahb_hwdata_out = hwdata_q;
  assign bus.ahb_hwstrb_out = hwstrb_q;
endmodule

// File: tb/tb_msrv32_dbus_ctrl.sv
// tb_msrv32_dbus_ctrl: directed and randomized transactions against a cycle-count model
module tb_msrv32_dbus_ctrl;
  import msrv32_pkg::*;
  localparam int T = 4;
  localparam int K_OK = 0, K_E1 = 1, K_E2 = 2;
  logic clk = 1'b0, rst_in = 1'b1;
  int checks = 0, errors = 0;
  msrv32_dbus_ctrl_if bus ();
  msrv32_dbus_ctrl #(.TIMEOUT_CYCLES(T)) dut (.clk_in(clk), .rst_in(rst_in), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_in = 1'b1;
    bus.req_valid_in = 1'b0;
    @(posedge clk);
    #1 rst_in = 1'b0;
    check("rst_ctl", 64'({bus.ahb_htrans_out, bus.stall_out, bus.rsp_valid_out, bus.req_ready_out}), 64'(5'b00001));
    check("rst_bus", 64'({bus.ahb_hwrite_out, bus.ahb_hsize_out, bus.ahb_hwstrb_out, bus.rsp_err_out}), 64'(0));
    check("rst_haddr", 64'(bus.ahb_haddr_out), 64'(0));
    check("rst_hwdata", 64'(bus.ahb_hwdata_out), 64'(0));
    check("rst_rdata", 64'(bus.rsp_rdata_out), 64'(0));
  endtask
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                     input logic [3:0] mask, input int aw, input int kind, input int w, input int e, input logic [31:0] rd);
    logic mis, err;
    logic [31:0] erd;
    int d, rsp, j;
    mis = size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    d = 2 + aw;
    if (mis) rsp = 1;
    else if (kind == K_OK) rsp = d + (w <= T ? w : T) + 1;
    else if (kind == K_E1) rsp = d + w + 1;
    else rsp = d + w + e + 2;
    err = mis || kind != K_OK || w > T;
    erd = (!wr && !err) ? rd : 32'd0;
    check("ready_idle", 64'(bus.req_ready_out), 64'(1));
    bus.req_valid_in = 1'b1;
    bus.req_write_in = wr;
    bus.req_addr_in = addr;
    bus.req_size_in = size;
    bus.req_wdata_in = wd;
    bus.req_mask_in = mask;
    bus.ahb_hready_in = 1'b1;
    bus.ahb_hresp_in = 1'b0;
    for (int k = 1; k <= rsp + 1; k++) begin
      @(posedge clk);
      #1;
      check("ctl", 64'({bus.ahb_htrans_out, bus.stall_out, bus.rsp_valid_out, bus.req_ready_out}),
            64'({(!mis && k <= 1 + aw) ? HTRANS_NONSEQ : HTRANS_IDLE, k < rsp, k == rsp, k == rsp + 1}));
      if (!mis && k <= 1 + aw)
        check("addr_phase", 64'({bus.ahb_haddr_out, bus.ahb_hwrite_out, bus.ahb_hsize_out}), 64'({addr, wr, 1'b0, size}));
      if (!mis && k == d)
        check("data_phase", 64'({bus.ahb_hwdata_out, bus.ahb_hwstrb_out}), wr ? 64'({wd, mask}) : 64'(0));
      if (k == rsp)
        check("rsp", 64'({bus.rsp_err_out, bus.rsp_rdata_out}), 64'({err, erd}));
      j = k - d;
      bus.ahb_hready_in = 1'b1;
      bus.ahb_hresp_in = 1'b0;
      bus.ahb_hrdata_in = $urandom;
      if (!mis && k <= aw) bus.ahb_hready_in = 1'b0;
      else if (!mis && k >= d && k < rsp) begin
        if (kind == K_OK) begin
          bus.ahb_hready_in = j == w;
          if (j == w) bus.ahb_hrdata_in = rd;
        end else if (kind == K_E1) begin
          bus.ahb_hready_in = j == w;
          bus.ahb_hresp_in = j == w;
        end else begin
          bus.ahb_hready_in = j == w + 1 + e;
          bus.ahb_hresp_in = j >= w;
        end
      end
      bus.req_valid_in = k <= rsp && $urandom_range(0, 1) == 1;
      bus.req_write_in = 1'($urandom);
      bus.req_addr_in = $urandom;
      bus.req_size_in = 2'($urandom);
      bus.req_wdata_in = $urandom;
      bus.req_mask_in = 4'($urandom);
    end
  endtask
  initial begin
    int kind, w;
    bus.req_valid_in = 1'b0;
    bus.req_write_in = 1'b0;
    bus.req_addr_in = '0;
    bus.req_size_in = '0;
    bus.req_wdata_in = '0;
    bus.req_mask_in = '0;
    bus.ahb_hready_in = 1'b1;
    bus.ahb_hresp_in = 1'b0;
    bus.ahb_hrdata_in = '0;
    do_reset();
    txn(1'b1, 32'h1000, SZ_WORD, 32'hDEADBEEF, 4'hF, 0, K_OK, 0, 0, 32'h0);
    txn(1'b0, 32'h2004, SZ_WORD, 32'h0, 4'h0, 0, K_OK, 3, 0, 32'h12345678);
    txn(1'b1, 32'h3001, SZ_HALF, 32'h0000ABCD, 4'h3, 0, K_OK, 0, 0, 32'h0);
    txn(1'b0, 32'h4000, SZ_WORD, 32'h0, 4'h0, 0, K_E2, 0, 0, 32'hCAFEF00D);
    txn(1'b0, 32'h4010, SZ_WORD, 32'h0, 4'h0, 1, K_E1, 2, 0, 32'hCAFEF00D);
    txn(1'b0, 32'h5000, SZ_WORD, 32'h0, 4'h0, 0, K_OK, T + 5, 0, 32'h55AA55AA);
    txn(1'b1, 32'h6002, SZ_HALF, 32'h12340000, 4'hC, 2, K_OK, T, 0, 32'h0);
    txn(1'b0, 32'h7003, SZ_BYTE, 32'h0, 4'h0, 0, K_OK, 1, 0, 32'h000000A5);
    txn(1'b0, 32'h8000, 2'd3, 32'h0, 4'h0, 0, K_OK, 0, 0, 32'h0);
    bus.req_valid_in = 1'b1;
    bus.req_write_in = 1'b0;
    bus.req_addr_in = 32'h40;
    bus.req_size_in = SZ_WORD;
    bus.ahb_hready_in = 1'b1;
    @(posedge clk);
    #1 bus.req_valid_in = 1'b0;
    @(posedge clk);
    #1 bus.ahb_hready_in = 1'b0;
    check("pre_rst_stall", 64'(bus.stall_out), 64'(1));
    @(posedge clk);
    #1;
    do_reset();
    bus.ahb_hready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 check("post_rst", 64'({bus.ahb_htrans_out, bus.stall_out, bus.rsp_valid_out, bus.req_ready_out}), 64'(5'b00001));
    end
    txn(1'b1, 32'h0000_0100, SZ_WORD, 32'h0BADC0DE, 4'hF, 0, K_OK, 0, 0, 32'h0);
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 2));
      w = kind == K_OK ? int'($urandom_range(0, T + 2)) : int'($urandom_range(0, T));
      txn(1'($urandom), $urandom, 2'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 2)),
          kind, w, int'($urandom_range(0, 2)), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
